// File: rtl/product_accumulator.sv
// product_accumulator: sums cfg_len+1 unsigned 8-bit products per frame and presents the frame total.
// Latency: out_valid rises the cycle after the last beat; in_ready returns the cycle after the output transfer.
// Backpressure: in_ready is low while a result is held; out_ready low holds the result indefinitely.
// Option: define PRODUCT_ACC_SAT_EN for saturating accumulation (default build wraps modulo 2^ACC_W).
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  if (ACC_W < 8) begin : g_acc_w_check
    $error("product_accumulator: ACC_W must be >= 8");
  end

  localparam logic [LEN_W-1:0] CNT_ONE = 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic             beat;
  logic             last;
  logic             carry;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_nxt;

  // A beat can only happen in ACCUM, so in_prod is ignored while holding a result.
  assign beat    = (state == ACCUM) && in_valid;
  assign sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, in_prod};
  assign carry   = sum_ext[ACC_W];

  // On the first beat len_q still holds the previous frame's length, so the
  // live cfg_len decides whether a one-beat frame ends immediately.
  assign last = (cnt == '0) ? (cfg_len == '0) : (cnt == len_q);

`ifdef PRODUCT_ACC_SAT_EN
  // Clamp on carry; once acc is all-ones any further add carries again (or adds zero), so it stays clamped.
  assign sum_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W; the carry is still recorded in the sticky overflow flag.
  assign sum_nxt = sum_ext[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave ACCUM on the last beat, leave HOLD on the output transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && last) state_nxt = HOLD;
      HOLD:    if (out_ready)    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decoded purely from state, with no combinational path from in_valid/out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // Datapath: accumulate per beat, capture the result and restart on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else if (beat) begin
      if (cnt == '0) begin
        len_q <= cfg_len;
      end
      if (last) begin
        out_acc <= sum_nxt;
        out_ovf <= ovf_q | carry;
        acc     <= '0;
        cnt     <= '0;
        ovf_q   <= 1'b0;
      end else begin
        acc     <= sum_nxt;
        cnt     <= cnt + CNT_ONE;
        ovf_q   <= ovf_q | carry;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=16 and ACC_W=8) share one input stream.
// Expected frame results come from a plain integer sum of each frame's products.
// Honours PRODUCT_ACC_SAT_EN for the expected 8-bit result.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic [3:0]  cfg_len;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_acc16;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_acc8;

  int checks   = 0;
  int failures = 0;
  int prods[$];

  product_accumulator #(.ACC_W(16), .LEN_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_prod(in_prod),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_ovf(out_ovf16)
  );

  product_accumulator #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready8), .in_prod(in_prod),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_acc(out_acc8), .out_ovf(out_ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid16"}, out_valid16, 0);
    check({tag, "_out_acc16"},   out_acc16,   0);
    check({tag, "_out_ovf16"},   out_ovf16,   0);
    check({tag, "_in_ready16"},  in_ready16,  1);
    check({tag, "_out_valid8"},  out_valid8,  0);
    check({tag, "_out_acc8"},    out_acc8,    0);
    check({tag, "_in_ready8"},   in_ready8,   1);
  endtask

  // Sends the frame held in prods (len+1 beats), then drains the result.
  // new_cfg >= 0 rewrites cfg_len after the first beat; stall > 0 holds out_ready low that many cycles.
  task automatic run_frame(input int len, input int max_bubble, input int stall, input int new_cfg);
    int          sum;
    logic [15:0] e16;
    logic        e16o;
    logic [7:0]  e8;
    logic        e8o;
    int          nb;
    sum = 0;
    foreach (prods[i]) sum += prods[i];
    e16  = sum[15:0];
    e16o = (sum > 65535);
    e8o  = (sum > 255);
`ifdef PRODUCT_ACC_SAT_EN
    e8   = e8o ? 8'hFF : sum[7:0];
`else
    e8   = sum[7:0];
`endif
    out_ready = (stall == 0);
    cfg_len   = len[3:0];
    for (int b = 0; b <= len; b++) begin
      nb = (max_bubble > 0) ? $urandom_range(0, max_bubble) : 0;
      for (int k = 0; k < nb; k++) begin
        in_valid = 1'b0;
        in_prod  = 8'($urandom_range(0, 255));
        step();
        check("bubble_out_valid", out_valid16, 0);
      end
      check("beat_in_ready16", in_ready16, 1);
      check("beat_in_ready8",  in_ready8,  1);
      in_valid = 1'b1;
      in_prod  = 8'(prods[b]);
      step();
      if (b == 0 && new_cfg >= 0) cfg_len = 4'(new_cfg);
      if (b < len) check("early_out_valid", out_valid16, 0);
    end
    // Keep offering junk while holding: it must be ignored.
    in_prod = 8'($urandom_range(1, 255));
    check("hold_out_valid16", out_valid16, 1);
    check("hold_in_ready16",  in_ready16,  0);
    check("hold_out_acc16",   out_acc16,   32'(e16));
    check("hold_out_ovf16",   out_ovf16,   32'(e16o));
    check("hold_out_valid8",  out_valid8,  1);
    check("hold_out_acc8",    out_acc8,    32'(e8));
    check("hold_out_ovf8",    out_ovf8,    32'(e8o));
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_out_valid16", out_valid16, 1);
      check("stall_in_ready16",  in_ready16,  0);
      check("stall_out_acc16",   out_acc16,   32'(e16));
      check("stall_out_acc8",    out_acc8,    32'(e8));
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("xfer_out_valid16", out_valid16, 0);
    check("xfer_in_ready16",  in_ready16,  1);
    check("xfer_out_valid8",  out_valid8,  0);
    check("xfer_in_ready8",   in_ready8,   1);
  endtask

  initial begin
    int len;
    rst       = 1'b1;
    cfg_len   = 4'd0;
    in_valid  = 1'b1;
    in_prod   = 8'd50;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid high.
    step();
    step();
    check_reset_outputs("reset");
    rst      = 1'b0;
    in_valid = 1'b0;

    // Basic four-beat frame, out_ready high throughout.
    prods = '{15, 30, 45, 225};
    run_frame(3, 0, 0, -1);

    // Same frame with bubbles, cfg_len dropped to 0 after the first beat.
    run_frame(3, 3, 0, 0);

    // Backpressure for five cycles.
    run_frame(3, 0, 5, -1);

    // Overflow in the 8-bit instance.
    prods = '{200, 100};
    run_frame(1, 0, 0, -1);

    // Saturation must stay sticky across later small and zero products.
    prods = '{250, 10, 0, 5};
    run_frame(3, 0, 1, -1);

    // Reset mid-frame discards the partial sum.
    cfg_len  = 4'd3;
    in_valid = 1'b1;
    in_prod  = 8'd10;
    step();
    in_prod  = 8'd20;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    check_reset_outputs("midreset");
    prods = '{1, 2, 3, 4};
    run_frame(3, 0, 0, -1);

    // Reset while holding a result.
    prods = '{7, 8};
    cfg_len  = 4'd1;
    in_valid = 1'b1;
    in_prod  = 8'd7;
    step();
    in_prod  = 8'd8;
    step();
    in_valid = 1'b0;
    check("pre_reset_hold", out_valid16, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("holdreset");

    // Randomised frames.
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(0, 15);
      prods.delete();
      for (int i = 0; i <= len; i++) prods.push_back($urandom_range(0, 255));
      run_frame(len, $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
